zynq_axi_port_arbiter: RTL and testbench

ZYNQ_AXI_PORT_ARBITER -- requirements
Module: zynq_axi_port_arbiter

---
 rtl/zynq_axi_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_zynq_axi_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zynq_axi_port_arbiter.sv
// Two-requester AXI3 port arbiter: independent AR/AW arbiters, ID-routed R/B, order-FIFO-routed W.
// Define ZYNQ_AXI_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: fixed priority to requester 0).
module zynq_axi_port_arbiter #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int len_width_p  = 4,
    parameter int id_width_p   = 5,
    parameter int wfifo_els_p  = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [addr_width_p-1:0]   s0_axi_araddr,
    input  logic [len_width_p-1:0]    s0_axi_arlen,
    input  logic [id_width_p-1:0]     s0_axi_arid,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [data_width_p-1:0]   s0_axi_rdata,
    output logic [id_width_p-1:0]     s0_axi_rid,
    output logic                      s0_axi_rlast,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready,
    input  logic [addr_width_p-1:0]   s0_axi_awaddr,
    input  logic [len_width_p-1:0]    s0_axi_awlen,
    input  logic [id_width_p-1:0]     s0_axi_awid,
    input  logic                      s0_axi_awvalid,
    output logic                      s0_axi_awready,
    input  logic [data_width_p-1:0]   s0_axi_wdata,
    input  logic [data_width_p/8-1:0] s0_axi_wstrb,
    input  logic [id_width_p-1:0]     s0_axi_wid,
    input  logic                      s0_axi_wlast,
    input  logic                      s0_axi_wvalid,
    output logic                      s0_axi_wready,
    output logic [id_width_p-1:0]     s0_axi_bid,
    output logic [1:0]                s0_axi_bresp,
    output logic                      s0_axi_bvalid,
    input  logic                      s0_axi_bready,

    input  logic [addr_width_p-1:0]   s1_axi_araddr,
    input  logic [len_width_p-1:0]    s1_axi_arlen,
    input  logic [id_width_p-1:0]     s1_axi_arid,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [data_width_p-1:0]   s1_axi_rdata,
    output logic [id_width_p-1:0]     s1_axi_rid,
    output logic                      s1_axi_rlast,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready,
    input  logic [addr_width_p-1:0]   s1_axi_awaddr,
    input  logic [len_width_p-1:0]    s1_axi_awlen,
    input  logic [id_width_p-1:0]     s1_axi_awid,
    input  logic                      s1_axi_awvalid,
    output logic                      s1_axi_awready,
    input  logic [data_width_p-1:0]   s1_axi_wdata,
    input  logic [data_width_p/8-1:0] s1_axi_wstrb,
    input  logic [id_width_p-1:0]     s1_axi_wid,
    input  logic                      s1_axi_wlast,
    input  logic                      s1_axi_wvalid,
    output logic                      s1_axi_wready,
    output logic [id_width_p-1:0]     s1_axi_bid,
    output logic [1:0]                s1_axi_bresp,
    output logic                      s1_axi_bvalid,
    input  logic                      s1_axi_bready,

    output logic [addr_width_p-1:0]   m00_axi_araddr,
    output logic [len_width_p-1:0]    m00_axi_arlen,
    output logic [id_width_p:0]       m00_axi_arid,
    output logic [2:0]                m00_axi_arsize,
    output logic [1:0]                m00_axi_arburst,
    output logic [3:0]                m00_axi_arcache,
    output logic [2:0]                m00_axi_arprot,
    output logic [3:0]                m00_axi_arqos,
    output logic [1:0]                m00_axi_arlock,
    output logic                      m00_axi_arvalid,
    input  logic                      m00_axi_arready,
    input  logic [data_width_p-1:0]   m00_axi_rdata,
    input  logic [id_width_p:0]       m00_axi_rid,
    input  logic                      m00_axi_rlast,
    input  logic [1:0]                m00_axi_rresp,
    input  logic                      m00_axi_rvalid,
    output logic                      m00_axi_rready,
    output logic [addr_width_p-1:0]   m00_axi_awaddr,
    output logic [len_width_p-1:0]    m00_axi_awlen,
    output logic [id_width_p:0]       m00_axi_awid,
    output logic [2:0]                m00_axi_awsize,
    output logic [1:0]                m00_axi_awburst,
    output logic [3:0]                m00_axi_awcache,
    output logic [2:0]                m00_axi_awprot,
    output logic [3:0]                m00_axi_awqos,
    output logic [1:0]                m00_axi_awlock,
    output logic                      m00_axi_awvalid,
    input  logic                      m00_axi_awready,
    output logic [data_width_p-1:0]   m00_axi_wdata,
    output logic [data_width_p/8-1:0] m00_axi_wstrb,
    output logic [id_width_p:0]       m00_axi_wid,
    output logic                      m00_axi_wlast,
    output logic                      m00_axi_wvalid,
    input  logic                      m00_axi_wready,
    input  logic [id_width_p:0]       m00_axi_bid,
    input  logic [1:0]                m00_axi_bresp,
    input  logic                      m00_axi_bvalid,
    output logic                      m00_axi_bready
);

    localparam int ptr_w = (wfifo_els_p > 1) ? $clog2(wfifo_els_p) : 1;
    localparam int cnt_w = $clog2(wfifo_els_p + 1);
    localparam logic [2:0] size_c = 3'($clog2(data_width_p / 8));

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    arb_state_e ar_state_q, ar_state_d, aw_state_q, aw_state_d;
    logic ar_held_q, ar_held_d, aw_held_q, aw_held_d;
    logic ar_gnt, ar_vld, ar_hs, aw_gnt, aw_vld, aw_hs;
    logic ar_last, aw_last;
    logic aw_req0, aw_req1;

    logic [wfifo_els_p-1:0] ord_q;
    logic [ptr_w-1:0]       wr_ptr_q, rd_ptr_q;
    logic [cnt_w-1:0]       cnt_q;
    logic                   fifo_full, fifo_empty, w_head, w_vld, w_pop;
    logic                   r_sel, b_sel;

    function automatic logic pick(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : ~v0;
    endfunction

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(wfifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef ZYNQ_AXI_ARB_ROUND_ROBIN_EN
    logic ar_last_q, aw_last_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_last_q <= 1'b1;
            aw_last_q <= 1'b1;
        end else begin
            if (ar_hs) ar_last_q <= ar_gnt;
            if (aw_hs) aw_last_q <= aw_gnt;
        end
    end

    assign ar_last = ar_last_q;
    assign aw_last = aw_last_q;
`else
    // A permanent "last = 1" makes the round-robin pick degenerate to fixed priority for requester 0.
    assign ar_last = 1'b1;
    assign aw_last = 1'b1;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_q <= ARB_IDLE;
            aw_state_q <= ARB_IDLE;
            ar_held_q  <= 1'b0;
            aw_held_q  <= 1'b0;
        end else begin
            ar_state_q <= ar_state_d;
            aw_state_q <= aw_state_d;
            ar_held_q  <= ar_held_d;
            aw_held_q  <= aw_held_d;
        end
    end

    assign fifo_full  = (cnt_q == cnt_w'(wfifo_els_p));
    assign fifo_empty = (cnt_q == '0);
    assign aw_req0    = s0_axi_awvalid && !fifo_full;
    assign aw_req1    = s1_axi_awvalid && !fifo_full;

    always_comb begin
        ar_state_d = ar_state_q;
        ar_held_d  = ar_held_q;
        ar_gnt     = (ar_state_q == ARB_HOLD) ? ar_held_q : pick(s0_axi_arvalid, s1_axi_arvalid, ar_last);
        ar_vld     = aresetn && (ar_gnt ? s1_axi_arvalid : s0_axi_arvalid);
        ar_hs      = ar_vld && m00_axi_arready;
        case (ar_state_q)
            ARB_IDLE: if (ar_vld && !m00_axi_arready) begin
                ar_state_d = ARB_HOLD;
                ar_held_d  = ar_gnt;
            end
            ARB_HOLD: if (ar_hs || !ar_vld) ar_state_d = ARB_IDLE;
            default:  ar_state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        aw_state_d = aw_state_q;
        aw_held_d  = aw_held_q;
        aw_gnt     = (aw_state_q == ARB_HOLD) ? aw_held_q : pick(aw_req0, aw_req1, aw_last);
        aw_vld     = aresetn && (aw_gnt ? aw_req1 : aw_req0);
        aw_hs      = aw_vld && m00_axi_awready;
        case (aw_state_q)
            ARB_IDLE: if (aw_vld && !m00_axi_awready) begin
                aw_state_d = ARB_HOLD;
                aw_held_d  = aw_gnt;
            end
            ARB_HOLD: if (aw_hs || !aw_vld) aw_state_d = ARB_IDLE;
            default:  aw_state_d = ARB_IDLE;
        endcase
    end

    assign m00_axi_arvalid = ar_vld;
    assign m00_axi_araddr  = ar_gnt ? s1_axi_araddr : s0_axi_araddr;
    assign m00_axi_arlen   = ar_gnt ? s1_axi_arlen  : s0_axi_arlen;
    assign m00_axi_arid    = {ar_gnt, ar_gnt ? s1_axi_arid : s0_axi_arid};
    assign s0_axi_arready  = ar_hs && !ar_gnt;
    assign s1_axi_arready  = ar_hs && ar_gnt;
    assign m00_axi_arsize  = size_c;
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_arcache = 4'b0011;
    assign m00_axi_arprot  = '0;
    assign m00_axi_arqos   = '0;
    assign m00_axi_arlock  = '0;

    assign m00_axi_awvalid = aw_vld;
    assign m00_axi_awaddr  = aw_gnt ? s1_axi_awaddr : s0_axi_awaddr;
    assign m00_axi_awlen   = aw_gnt ? s1_axi_awlen  : s0_axi_awlen;
    assign m00_axi_awid    = {aw_gnt, aw_gnt ? s1_axi_awid : s0_axi_awid};
    assign s0_axi_awready  = aw_hs && !aw_gnt;
    assign s1_axi_awready  = aw_hs && aw_gnt;
    assign m00_axi_awsize  = size_c;
    assign m00_axi_awburst = 2'b01;
    assign m00_axi_awcache = 4'b0011;
    assign m00_axi_awprot  = '0;
    assign m00_axi_awqos   = '0;
    assign m00_axi_awlock  = '0;

    // Order FIFO: one bit per accepted AW burst naming the requester whose W beats come next.
    always_ff @(posedge aclk) begin
        if (aw_hs) ord_q[wr_ptr_q] <= aw_gnt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (aw_hs) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({aw_hs, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign w_head         = ord_q[rd_ptr_q];
    assign w_vld          = aresetn && !fifo_empty && (w_head ? s1_axi_wvalid : s0_axi_wvalid);
    assign w_pop          = w_vld && m00_axi_wready && m00_axi_wlast;
    assign m00_axi_wvalid = w_vld;
    assign m00_axi_wdata  = w_head ? s1_axi_wdata : s0_axi_wdata;
    assign m00_axi_wstrb  = w_head ? s1_axi_wstrb : s0_axi_wstrb;
    assign m00_axi_wlast  = w_head ? s1_axi_wlast : s0_axi_wlast;
    assign m00_axi_wid    = {w_head, w_head ? s1_axi_wid : s0_axi_wid};
    assign s0_axi_wready  = aresetn && !fifo_empty && !w_head && m00_axi_wready;
    assign s1_axi_wready  = aresetn && !fifo_empty && w_head && m00_axi_wready;

    assign r_sel          = m00_axi_rid[id_width_p];
    assign s0_axi_rvalid  = aresetn && m00_axi_rvalid && !r_sel;
    assign s1_axi_rvalid  = aresetn && m00_axi_rvalid && r_sel;
    assign m00_axi_rready = aresetn && (r_sel ? s1_axi_rready : s0_axi_rready);
    assign s0_axi_rdata   = m00_axi_rdata;
    assign s1_axi_rdata   = m00_axi_rdata;
    assign s0_axi_rid     = m00_axi_rid[id_width_p-1:0];
    assign s1_axi_rid     = m00_axi_rid[id_width_p-1:0];
    assign s0_axi_rlast   = m00_axi_rlast;
    assign s1_axi_rlast   = m00_axi_rlast;
    assign s0_axi_rresp   = m00_axi_rresp;
    assign s1_axi_rresp   = m00_axi_rresp;

    assign b_sel          = m00_axi_bid[id_width_p];
    assign s0_axi_bvalid  = aresetn && m00_axi_bvalid && !b_sel;
    assign s1_axi_bvalid  = aresetn && m00_axi_bvalid && b_sel;
    assign m00_axi_bready = aresetn && (b_sel ? s1_axi_bready : s0_axi_bready);
    assign s0_axi_bid     = m00_axi_bid[id_width_p-1:0];
    assign s1_axi_bid     = m00_axi_bid[id_width_p-1:0];
    assign s0_axi_bresp   = m00_axi_bresp;
    assign s1_axi_bresp   = m00_axi_bresp;

endmodule

// File: tb/tb_zynq_axi_port_arbiter.sv
// Directed self-checking bench for zynq_axi_port_arbiter; expectations follow ZYNQ_AXI_ARB_ROUND_ROBIN_EN.
module tb_zynq_axi_port_arbiter;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_wdata, s1_wdata;
    logic [3:0]  s0_arlen, s1_arlen, s0_awlen, s1_awlen, s0_wstrb, s1_wstrb;
    logic [4:0]  s0_arid, s1_arid, s0_awid, s1_awid, s0_wid, s1_wid;
    logic        s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid;
    logic        s0_wlast, s1_wlast, s0_rready, s1_rready, s0_bready, s1_bready;
    logic        s0_arready, s1_arready, s0_awready, s1_awready, s0_wready, s1_wready;
    logic [31:0] s0_rdata, s1_rdata;
    logic [4:0]  s0_rid, s1_rid, s0_bid, s1_bid;
    logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_bvalid, s1_bvalid;
    logic [1:0]  s0_rresp, s1_rresp, s0_bresp, s1_bresp;

    logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
    logic [3:0]  m_arlen, m_awlen, m_arcache, m_awcache, m_arqos, m_awqos, m_wstrb;
    logic [5:0]  m_arid, m_awid, m_rid, m_wid, m_bid;
    logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
    logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
    logic        m_arvalid, m_arready, m_awvalid, m_awready, m_rlast, m_rvalid, m_rready;
    logic        m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned s0_cnt, s1_cnt;

    zynq_axi_port_arbiter #(.addr_width_p(32), .data_width_p(32), .len_width_p(4),
                            .id_width_p(5), .wfifo_els_p(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axi_araddr(s0_araddr), .s0_axi_arlen(s0_arlen), .s0_axi_arid(s0_arid),
        .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready),
        .s0_axi_rdata(s0_rdata), .s0_axi_rid(s0_rid), .s0_axi_rlast(s0_rlast),
        .s0_axi_rresp(s0_rresp), .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s0_rready),
        .s0_axi_awaddr(s0_awaddr), .s0_axi_awlen(s0_awlen), .s0_axi_awid(s0_awid),
        .s0_axi_awvalid(s0_awvalid), .s0_axi_awready(s0_awready),
        .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wid(s0_wid),
        .s0_axi_wlast(s0_wlast), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(s0_wready),
        .s0_axi_bid(s0_bid), .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid),
        .s0_axi_bready(s0_bready),
        .s1_axi_araddr(s1_araddr), .s1_axi_arlen(s1_arlen), .s1_axi_arid(s1_arid),
        .s1_axi_arvalid(s1_arvalid), .s1_axi_arready(s1_arready),
        .s1_axi_rdata(s1_rdata), .s1_axi_rid(s1_rid), .s1_axi_rlast(s1_rlast),
        .s1_axi_rresp(s1_rresp), .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(s1_rready),
        .s1_axi_awaddr(s1_awaddr), .s1_axi_awlen(s1_awlen), .s1_axi_awid(s1_awid),
        .s1_axi_awvalid(s1_awvalid), .s1_axi_awready(s1_awready),
        .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb), .s1_axi_wid(s1_wid),
        .s1_axi_wlast(s1_wlast), .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(s1_wready),
        .s1_axi_bid(s1_bid), .s1_axi_bresp(s1_bresp), .s1_axi_bvalid(s1_bvalid),
        .s1_axi_bready(s1_bready),
        .m00_axi_araddr(m_araddr), .m00_axi_arlen(m_arlen), .m00_axi_arid(m_arid),
        .m00_axi_arsize(m_arsize), .m00_axi_arburst(m_arburst), .m00_axi_arcache(m_arcache),
        .m00_axi_arprot(m_arprot), .m00_axi_arqos(m_arqos), .m00_axi_arlock(m_arlock),
        .m00_axi_arvalid(m_arvalid), .m00_axi_arready(m_arready),
        .m00_axi_rdata(m_rdata), .m00_axi_rid(m_rid), .m00_axi_rlast(m_rlast),
        .m00_axi_rresp(m_rresp), .m00_axi_rvalid(m_rvalid), .m00_axi_rready(m_rready),
        .m00_axi_awaddr(m_awaddr), .m00_axi_awlen(m_awlen), .m00_axi_awid(m_awid),
        .m00_axi_awsize(m_awsize), .m00_axi_awburst(m_awburst), .m00_axi_awcache(m_awcache),
        .m00_axi_awprot(m_awprot), .m00_axi_awqos(m_awqos), .m00_axi_awlock(m_awlock),
        .m00_axi_awvalid(m_awvalid), .m00_axi_awready(m_awready),
        .m00_axi_wdata(m_wdata), .m00_axi_wstrb(m_wstrb), .m00_axi_wid(m_wid),
        .m00_axi_wlast(m_wlast), .m00_axi_wvalid(m_wvalid), .m00_axi_wready(m_wready),
        .m00_axi_bid(m_bid), .m00_axi_bresp(m_bresp), .m00_axi_bvalid(m_bvalid),
        .m00_axi_bready(m_bready)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        {s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_wdata, s1_wdata} = '0;
        {s0_arlen, s1_arlen, s0_awlen, s1_awlen, s0_wstrb, s1_wstrb} = '0;
        {s0_arid, s1_arid, s0_awid, s1_awid, s0_wid, s1_wid} = '0;
        {s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid} = '0;
        {s0_wlast, s1_wlast, s0_rready, s1_rready, s0_bready, s1_bready} = '0;
        {m_rdata, m_rid, m_rlast, m_rresp, m_rvalid, m_bid, m_bresp, m_bvalid} = '0;
        {m_arready, m_awready, m_wready} = '0;

        // Reset: valids presented on every side must not propagate
        tick();
        s0_arvalid = 1'b1; s0_awvalid = 1'b1; s0_wvalid = 1'b1;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        m_rvalid = 1'b1; m_rid = 6'h21; m_bvalid = 1'b1; m_bid = 6'h03;
        #1;
        check("rst_arvalid", m_arvalid, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_s1_rvalid", s1_rvalid, 0);
        check("rst_s0_bvalid", s0_bvalid, 0);
        check("rst_s0_arready", s0_arready, 0);
        check("rst_s0_wready", s0_wready, 0);
        tick();
        aresetn = 1'b1;
        {s0_arvalid, s0_awvalid, s0_wvalid, m_rvalid, m_bvalid} = '0;
        {m_arready, m_awready, m_wready} = '0;

        // Simultaneous AR requests after reset
        s0_arvalid = 1'b1; s0_araddr = 32'h1000; s0_arid = 5'h03; s0_arlen = 4'd2;
        s1_arvalid = 1'b1; s1_araddr = 32'h2000; s1_arid = 5'h0A; s1_arlen = 4'd1;
        m_arready = 1'b1;
        #1;
        check("ar0_arvalid", m_arvalid, 1);
        check("ar0_arid", m_arid, 6'h03);
        check("ar0_araddr", m_araddr, 32'h1000);
        check("ar0_arlen", m_arlen, 4'd2);
        check("ar0_s0_arready", s0_arready, 1);
        check("ar0_s1_arready", s1_arready, 0);
        check("tie_arsize", m_arsize, 3'd2);
        check("tie_arburst", m_arburst, 2'b01);
        check("tie_arcache", m_arcache, 4'b0011);
        check("tie_arlock", m_arlock, 2'b00);
        check("tie_awcache", m_awcache, 4'b0011);
        tick();
        s0_araddr = 32'h1100;
        #1;
`ifdef ZYNQ_AXI_ARB_ROUND_ROBIN_EN
        check("ar1_arid", m_arid, 6'h2A);
        check("ar1_s1_arready", s1_arready, 1);
        check("ar1_s0_arready", s0_arready, 0);
`else
        check("ar1_arid", m_arid, 6'h03);
        check("ar1_s0_arready", s0_arready, 1);
        check("ar1_s1_arready", s1_arready, 0);
`endif
        tick();
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_arready = 1'b0;

        // Grant hold: s1 waits on arready while higher-priority s0 arrives
        s1_arvalid = 1'b1;
        #1;
        check("hold_arvalid", m_arvalid, 1);
        check("hold_arid0", m_arid, 6'h2A);
        check("hold_s1_arready", s1_arready, 0);
        tick();
        s0_arvalid = 1'b1;
        #1;
        check("hold_arid1", m_arid, 6'h2A);
        check("hold_araddr", m_araddr, 32'h2000);
        tick();
        m_arready = 1'b1;
        #1;
        check("hold_rel_s1_arready", s1_arready, 1);
        check("hold_rel_s0_arready", s0_arready, 0);
        tick();
        s1_arvalid = 1'b0;
        #1;
        check("hold_next_arid", m_arid, 6'h03);
        check("hold_next_s0_arready", s0_arready, 1);
        tick();
        s0_arvalid = 1'b0; m_arready = 1'b0;

        // R and B routing on ID MSB
        m_rvalid = 1'b1; m_rid = 6'h21; m_rdata = 32'hDEAD_BEEF; s1_rready = 1'b1;
        #1;
        check("r_s1_rvalid", s1_rvalid, 1);
        check("r_s1_rid", s1_rid, 5'h01);
        check("r_s1_rdata", s1_rdata, 32'hDEAD_BEEF);
        check("r_s0_rvalid", s0_rvalid, 0);
        check("r_rready_go", m_rready, 1);
        s1_rready = 1'b0; s0_rready = 1'b1;
        #1;
        check("r_rready_stall", m_rready, 0);
        m_rid = 6'h05;
        #1;
        check("r_s0_rvalid", s0_rvalid, 1);
        check("r_s1_rvalid_off", s1_rvalid, 0);
        check("r_s0_rready", m_rready, 1);
        m_rvalid = 1'b0; s0_rready = 1'b0;
        m_bvalid = 1'b1; m_bid = 6'h23; m_bresp = 2'b10; s1_bready = 1'b1;
        #1;
        check("b_s1_bvalid", s1_bvalid, 1);
        check("b_s1_bid", s1_bid, 5'h03);
        check("b_s1_bresp", s1_bresp, 2'b10);
        check("b_s0_bvalid", s0_bvalid, 0);
        check("b_bready", m_bready, 1);
        m_bvalid = 1'b0; s1_bready = 1'b0;

        // W blocked while no AW has been accepted
        s0_wvalid = 1'b1; s1_wvalid = 1'b1; m_wready = 1'b1;
        s0_wdata = 32'hA0A0_0000; s0_wid = 5'h02; s0_wlast = 1'b1; s0_wstrb = 4'hF;
        s1_wdata = 32'hB1B1_0000; s1_wid = 5'h07; s1_wlast = 1'b0; s1_wstrb = 4'h3;
        #1;
        check("wempty_wvalid", m_wvalid, 0);
        check("wempty_s0_wready", s0_wready, 0);
        check("wempty_s1_wready", s1_wready, 0);

        // s1 AW len=3 then s0 AW len=0; W order follows AW order
        m_awready = 1'b1;
        s1_awvalid = 1'b1; s1_awlen = 4'd3; s1_awid = 5'h07; s1_awaddr = 32'h3000;
        #1;
        check("aw_s1_awid", m_awid, 6'h27);
        check("aw_s1_awlen", m_awlen, 4'd3);
        check("aw_s1_awready", s1_awready, 1);
        check("aw_s1_wvalid_pre", m_wvalid, 0);
        tick();
        s1_awvalid = 1'b0;
        s0_awvalid = 1'b1; s0_awlen = 4'd0; s0_awid = 5'h02; s0_awaddr = 32'h4000;
        #1;
        check("aw_s0_awid", m_awid, 6'h02);
        check("aw_s0_awaddr", m_awaddr, 32'h4000);
        check("w_b0_wid", m_wid, 6'h27);
        check("w_b0_wdata", m_wdata, 32'hB1B1_0000);
        check("w_b0_s1_wready", s1_wready, 1);
        check("w_b0_s0_wready", s0_wready, 0);
        tick();
        s0_awvalid = 1'b0;
        for (int b = 1; b < 4; b++) begin
            s1_wdata = 32'hB1B1_0000 + b;
            s1_wlast = (b == 3);
            #1;
            check("w_s1_wid", m_wid, 6'h27);
            check("w_s1_wdata", m_wdata, 32'hB1B1_0000 + b);
            check("w_s1_wlast", m_wlast, (b == 3));
            tick();
        end
        s1_wvalid = 1'b0; s1_wlast = 1'b0;
        #1;
        check("w_s0_wid", m_wid, 6'h02);
        check("w_s0_wdata", m_wdata, 32'hA0A0_0000);
        check("w_s0_wstrb", m_wstrb, 4'hF);
        check("w_s0_s0_wready", s0_wready, 1);
        check("w_s0_s1_wready", s1_wready, 0);
        tick();
        check("w_drained_wvalid", m_wvalid, 0);
        s0_wvalid = 1'b0;

        // FIFO full: fifth AW held off until a wlast handshake
        m_wready = 1'b0;
        s0_awvalid = 1'b1; s0_awid = 5'h04;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_fill_awready", s0_awready, 1);
            tick();
        end
        #1;
        check("full_5th_awready", s0_awready, 0);
        check("full_5th_awvalid", m_awvalid, 0);
        tick();
        check("full_still_awready", s0_awready, 0);
        s0_wvalid = 1'b1; s0_wlast = 1'b1; m_wready = 1'b1;
        #1;
        check("full_pop_wready", s0_wready, 1);
        check("full_pop_awready", s0_awready, 0);
        tick();
        m_wready = 1'b0;
        #1;
        check("full_after_pop_awready", s0_awready, 1);
        tick();
        check("full_again_awready", s0_awready, 0);

        // Simultaneous push and pop keeps occupancy
        m_wready = 1'b1;
        #1;
        check("sim_pop_only_awready", s0_awready, 0);
        tick();
        check("sim_push_awready", s0_awready, 1);
        check("sim_pop_wready", s0_wready, 1);
        tick();
        m_wready = 1'b0;
        #1;
        check("sim_one_slot_awready", s0_awready, 1);
        tick();
        check("sim_full_awready", s0_awready, 0);

        // Reset mid-W burst, then a fresh AW must route W from an empty FIFO
        m_wready = 1'b1; s0_wlast = 1'b0;
        s1_arvalid = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1; m_rid = 6'h21; s1_rready = 1'b1;
        #1;
        check("mid_wvalid", m_wvalid, 1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_wvalid", m_wvalid, 0);
        check("mid_rst_awvalid", m_awvalid, 0);
        check("mid_rst_arvalid", m_arvalid, 0);
        check("mid_rst_s1_rvalid", s1_rvalid, 0);
        check("mid_rst_s0_wready", s0_wready, 0);
        check("mid_rst_s1_arready", s1_arready, 0);
        tick();
        aresetn = 1'b1;
        {s0_awvalid, s1_arvalid, m_rvalid, s1_rready} = '0;
        s1_awvalid = 1'b1; s1_awid = 5'h11; s1_awlen = 4'd0;
        #1;
        check("post_awid", m_awid, 6'h31);
        check("post_s1_awready", s1_awready, 1);
        check("post_wvalid_empty", m_wvalid, 0);
        tick();
        s1_awvalid = 1'b0;
        s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wid = 5'h11; s1_wdata = 32'hC0DE_0001;
        #1;
        check("post_wid", m_wid, 6'h31);
        check("post_wdata", m_wdata, 32'hC0DE_0001);
        check("post_s1_wready", s1_wready, 1);
        check("post_s0_wready", s0_wready, 0);
        tick();
        check("post_drained_wvalid", m_wvalid, 0);
        {s0_wvalid, s1_wvalid, s0_wlast, s1_wlast, m_wready} = '0;

        // Sustained contention on AR for 100 cycles
        s0_cnt = 0; s1_cnt = 0;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_arready = 1'b1;
        repeat (100) begin
            #1;
            if (m_arvalid && s1_arready) s1_cnt++;
            if (m_arvalid && s0_arready) s0_cnt++;
            tick();
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
`ifdef ZYNQ_AXI_ARB_ROUND_ROBIN_EN
        check("rr_s0_grants", s0_cnt, 50);
        check("rr_s1_grants", s1_cnt, 50);
`else
        check("fp_s0_grants", s0_cnt, 100);
        check("fp_s1_grants", s1_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
